// File: rtl/module_multicycle_wide_adder_pkg.sv
// Shared definitions for the multicycle wide adder.
//   state_t / ST_*  : controller state encoding (IDLE, RUN, DONE)
//   wide_of()       : full operand width from slice width and slice count
`timescale 1ns/1ps
package pkg_wide_adder;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int wide_of(input int cla_width, input int num_chunks);
        return cla_width * num_chunks;
    endfunction

endpackage

// File: rtl/module_multicycle_wide_adder_if.sv
// Request/response bundle for the multicycle wide adder.
//   request  : valid_i, ready_o, a_i, b_i, carry_i
//   response : valid_o, ready_i, sum_o, carry_o, ovf_o
//   status   : busy_o
// master = requester/consumer side, slave = adder side.
`timescale 1ns/1ps
interface module_multicycle_wide_adder_if #(
    parameter int WIDE = 128
);
    logic            valid_i;
    logic            ready_o;
    logic [WIDE-1:0] a_i;
    logic [WIDE-1:0] b_i;
    logic            carry_i;
    logic            valid_o;
    logic            ready_i;
    logic [WIDE-1:0] sum_o;
    logic            carry_o;
    logic            ovf_o;
    logic            busy_o;

    modport master (
        output valid_i, a_i, b_i, carry_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, ovf_o, busy_o
    );

    modport slave (
        input  valid_i, a_i, b_i, carry_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, ovf_o, busy_o
    );
endinterface

// File: rtl/module_multicycle_wide_adder_cla_slice.sv
// Combinational W-bit carry-lookahead adder slice.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : a + b + cin (low W bits)
//   cout : true carry out of bit W-1
`timescale 1ns/1ps
module module_cla_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         run;

    // Each carry is the flattened lookahead sum-of-products:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, so no carry depends
    // on another carry term.
    always_comb begin
        g   = a & b;
        p   = a ^ b;
        c   = '0;
        run = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i];
            run    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & run);
                run    = run & p[j];
            end
            c[i+1] = c[i+1] | (run & cin);
        end
        sum  = p ^ c[W-1:0];
        cout = c[W];
    end
endmodule

// File: rtl/module_multicycle_wide_adder.sv
// Multicycle wide adder: adds WIDE = CLA_WIDTH*NUM_CHUNKS bit operands one
// CLA_WIDTH slice per clock (LSB slice first) through a single shared CLA
// slice, carrying between slices in a register.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus (slave)    : valid/ready request (a_i, b_i, carry_i) and
//                    valid/ready response (sum_o, carry_o, ovf_o), busy_o
`timescale 1ns/1ps
module module_multicycle_wide_adder
    import pkg_wide_adder::*;
#(
    parameter int CLA_WIDTH  = 32,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    module_multicycle_wide_adder_if.slave bus
);
    localparam int WIDE  = wide_of(CLA_WIDTH, NUM_CHUNKS);
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              carry_q;
    logic [WIDE-1:0]   a_q;
    logic [WIDE-1:0]   b_q;
    logic [WIDE-1:0]   sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              valid_q;

    logic [CLA_WIDTH-1:0] slice_a;
    logic [CLA_WIDTH-1:0] slice_b;
    logic [CLA_WIDTH-1:0] slice_sum;
    logic                 slice_cout;

    assign slice_a = a_q[idx*CLA_WIDTH +: CLA_WIDTH];
    assign slice_b = b_q[idx*CLA_WIDTH +: CLA_WIDTH];

    module_cla_slice #(.W(CLA_WIDTH)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        carry_q <= bus.carry_i;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[idx*CLA_WIDTH +: CLA_WIDTH] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx == LAST_IDX) begin
                        // Top slice: its MSB is the result sign bit.
                        idx     <= '0;
                        cout_q  <= slice_cout;
                        ovf_q   <= (a_q[WIDE-1] == b_q[WIDE-1]) &&
                                   (slice_sum[CLA_WIDTH-1] != a_q[WIDE-1]);
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_o = (state == ST_IDLE);
    assign bus.busy_o  = (state != ST_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.sum_o   = sum_q;
    assign bus.carry_o = cout_q;
    assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_module_multicycle_wide_adder.sv
`timescale 1ns/1ps
module tb_module_multicycle_wide_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Small instance for directed cases, default-sized instance for random.
    module_multicycle_wide_adder_if #(.WIDE(32))  s_if ();
    module_multicycle_wide_adder_if #(.WIDE(128)) w_if ();

    module_multicycle_wide_adder #(.CLA_WIDTH(8), .NUM_CHUNKS(4)) dut_s (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (s_if.slave)
    );

    module_multicycle_wide_adder dut_w (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (w_if.slave)
    );

    // Drives one request into the small DUT (caller ensures IDLE at a
    // post-edge sample point), scrambles the operands after acceptance,
    // and returns the result plus edges from accept to valid_o.
    task automatic run_small(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             output logic [31:0] sum, output logic co, output logic ov,
                             output int lat);
        s_if.valid_i = 1'b1; s_if.a_i = a; s_if.b_i = b; s_if.carry_i = cin; s_if.ready_i = 1'b0;
        @(posedge clk); #1;
        s_if.valid_i = 1'b0; s_if.a_i = $urandom; s_if.b_i = $urandom; s_if.carry_i = ~cin;
        lat = 0;
        while (!s_if.valid_o && lat < 20) begin @(posedge clk); #1; lat++; end
        sum = s_if.sum_o; co = s_if.carry_o; ov = s_if.ovf_o;
        s_if.ready_i = 1'b1;
        @(posedge clk); #1;
        s_if.ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++; if (s_if.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", s_if.ready_o); end
        n_checks++; if (s_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", s_if.valid_o); end
        n_checks++; if (s_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", s_if.busy_o); end
        n_checks++; if (s_if.sum_o !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", s_if.sum_o); end
        n_checks++; if ({s_if.carry_o, s_if.ovf_o} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {s_if.carry_o, s_if.ovf_o}); end
        n_checks++; if (w_if.ready_o !== 1'b1 || w_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wide: got rdy=%b vld=%b expected 1 0", w_if.ready_o, w_if.valid_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vc [4];
        logic [31:0] es [4];
        logic        ec [4];
        logic        eo [4];
        logic [31:0] sum;
        logic        co, ov;
        int          lat;
        va = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        vb = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000};
        vc = '{1'b0, 1'b1, 1'b0, 1'b0};
        es = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h00000000};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (s_if.ready_o !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready: got %b expected 1", k, s_if.ready_o); end
            run_small(va[k], vb[k], vc[k], sum, co, ov, lat);
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 4", k, lat); end
            n_checks++; if (sum !== es[k]) begin n_fail++; $display("FAIL dir%0d_sum: got %h expected %h", k, sum, es[k]); end
            n_checks++; if (co !== ec[k]) begin n_fail++; $display("FAIL dir%0d_carry: got %b expected %b", k, co, ec[k]); end
            n_checks++; if (ov !== eo[k]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b expected %b", k, ov, eo[k]); end
            n_checks++; if (s_if.valid_o !== 1'b0 || s_if.ready_o !== 1'b1) begin n_fail++; $display("FAIL dir%0d_release: got vld=%b rdy=%b expected 0 1", k, s_if.valid_o, s_if.ready_o); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        s_if.valid_i = 1'b1; s_if.a_i = 32'h10; s_if.b_i = 32'h20; s_if.carry_i = 1'b0; s_if.ready_i = 1'b0;
        @(posedge clk); #1;
        // Keep offering a different request while busy; it must be ignored.
        s_if.a_i = 32'hDEAD0000; s_if.b_i = 32'h0000BEEF; s_if.carry_i = 1'b1;
        lat = 0;
        while (!s_if.valid_o && lat < 20) begin
            n_checks++; if (s_if.ready_o !== 1'b0 || s_if.busy_o !== 1'b1) begin n_fail++; $display("FAIL bp_run_ready: got rdy=%b busy=%b expected 0 1", s_if.ready_o, s_if.busy_o); end
            @(posedge clk); #1; lat++;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        repeat (5) begin
            @(posedge clk); #1;
            n_checks++; if (s_if.valid_o !== 1'b1 || s_if.ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_hs: got vld=%b rdy=%b expected 1 0", s_if.valid_o, s_if.ready_o); end
            n_checks++; if (s_if.sum_o !== 32'h30 || s_if.carry_o !== 1'b0 || s_if.ovf_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_data: got %h %b %b expected 30 0 0", s_if.sum_o, s_if.carry_o, s_if.ovf_o); end
        end
        s_if.ready_i = 1'b1;
        @(posedge clk); #1;
        s_if.ready_i = 1'b0;
        n_checks++; if (s_if.valid_o !== 1'b0 || s_if.ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", s_if.valid_o, s_if.ready_o); end
        // The still-asserted request is now accepted.
        @(posedge clk); #1;
        s_if.valid_i = 1'b0;
        lat = 0;
        while (!s_if.valid_o && lat < 20) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
        n_checks++; if (s_if.sum_o !== 32'hDEADBEF0 || s_if.carry_o !== 1'b0 || s_if.ovf_o !== 1'b0) begin n_fail++; $display("FAIL bp_next_data: got %h %b %b expected deadbef0 0 0", s_if.sum_o, s_if.carry_o, s_if.ovf_o); end
        s_if.ready_i = 1'b1;
        @(posedge clk); #1;
        s_if.ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] sum;
        logic        co, ov;
        int          lat;
        s_if.valid_i = 1'b1; s_if.a_i = 32'hFF; s_if.b_i = 32'h1; s_if.carry_i = 1'b0;
        @(posedge clk); #1;
        s_if.valid_i = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        n_checks++; if (s_if.busy_o !== 1'b1 || s_if.sum_o === 32'h0) begin n_fail++; $display("FAIL rst_pre: got busy=%b sum=%h expected busy 1 and partial sum", s_if.busy_o, s_if.sum_o); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (s_if.valid_o !== 1'b0 || s_if.busy_o !== 1'b0 || s_if.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_hs: got vld=%b busy=%b rdy=%b expected 0 0 1", s_if.valid_o, s_if.busy_o, s_if.ready_o); end
        n_checks++; if (s_if.sum_o !== 32'h0 || s_if.carry_o !== 1'b0 || s_if.ovf_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data: got %h %b %b expected 0 0 0", s_if.sum_o, s_if.carry_o, s_if.ovf_o); end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (s_if.ready_o !== 1'b1 || s_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_release: got rdy=%b vld=%b expected 1 0", s_if.ready_o, s_if.valid_o); end
        run_small(32'h000000FF, 32'h00000001, 1'b0, sum, co, ov, lat);
        n_checks++; if (lat !== 4 || sum !== 32'h100 || co !== 1'b0 || ov !== 1'b0) begin n_fail++; $display("FAIL rst_after_op: got lat=%0d %h %b %b expected 4 100 0 0", lat, sum, co, ov); end
    endtask

    task automatic test_random;
        logic [127:0] a, b, held;
        logic         cin;
        logic [128:0] u;
        logic [129:0] e;
        int           lat, stall;
        for (int k = 0; k < 1000; k++) begin
            a   = {$urandom, $urandom, $urandom, $urandom};
            b   = {$urandom, $urandom, $urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            if (k % 10 == 0) b = ~a;                     // full-width carry chain
            if (k % 10 == 1) begin a[127] = 1'b0; b[127] = 1'b0; end
            // Reference: unsigned carry from a wide sum; signed overflow from
            // a sign-extended sum not fitting 128 bits.
            u = {1'b0, a} + {1'b0, b} + 129'(cin);
            e = {{2{a[127]}}, a} + {{2{b[127]}}, b} + 130'(cin);
            w_if.valid_i = 1'b1; w_if.a_i = a; w_if.b_i = b; w_if.carry_i = cin;
            w_if.ready_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            w_if.valid_i = 1'b0; w_if.a_i = ~a; w_if.b_i = {$urandom, $urandom, $urandom, $urandom};
            lat = 0;
            while (!w_if.valid_o && lat < 20) begin
                w_if.ready_i = 1'($urandom_range(0, 1));
                @(posedge clk); #1; lat++;
            end
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected 4", k, lat); end
            n_checks++; if (w_if.sum_o !== u[127:0]) begin n_fail++; $display("FAIL rnd%0d_sum: got %h expected %h", k, w_if.sum_o, u[127:0]); end
            n_checks++; if (w_if.carry_o !== u[128]) begin n_fail++; $display("FAIL rnd%0d_carry: got %b expected %b", k, w_if.carry_o, u[128]); end
            n_checks++; if (w_if.ovf_o !== (e[128] != e[127])) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b expected %b", k, w_if.ovf_o, e[128] != e[127]); end
            held  = w_if.sum_o;
            stall = $urandom_range(0, 3);
            w_if.ready_i = 1'b0;
            repeat (stall) begin @(posedge clk); #1; end
            n_checks++; if (w_if.valid_o !== 1'b1 || w_if.sum_o !== held) begin n_fail++; $display("FAIL rnd%0d_stall: got vld=%b sum=%h expected 1 %h", k, w_if.valid_o, w_if.sum_o, held); end
            w_if.ready_i = 1'b1;
            @(posedge clk); #1;
            w_if.ready_i = 1'b0;
            n_checks++; if (w_if.ready_o !== 1'b1 || w_if.valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_release: got rdy=%b vld=%b expected 1 0", k, w_if.ready_o, w_if.valid_o); end
        end
    endtask

    initial begin
        s_if.valid_i = 1'b0; s_if.a_i = '0; s_if.b_i = '0; s_if.carry_i = 1'b0; s_if.ready_i = 1'b0;
        w_if.valid_i = 1'b0; w_if.a_i = '0; w_if.b_i = '0; w_if.carry_i = 1'b0; w_if.ready_i = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
